fetch_pc_ctrl: RTL

- Sequences the instruction-fetch stage. Owns the PC register and the request/acknowledge handshake to instruction memory.
- Presents fetched instructions downstream through a one-entry valid/ready buffer.
- Applies branch targets (PC+4 + word offset shifted left by 2) and jump targets on redirect.
- Sits between the branch/jump resolution logic and the instruction memory port.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_target_calc.sv | 30 +++
 rtl/fetch_pc_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target generation: branch (PC+4 + offset*4) or jump (region of PC+4 with word index).
module fetch_target_calc
  import fetch_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] br_pc,
  input  logic [31:0]   br_offset,
  input  logic [25:0]   jmp_index,
  input  logic          br_taken,
  output logic [AW-1:0] target
);

  logic [AW-1:0] seq_pc_s;
  logic [AW-1:0] br_disp_s;

  assign seq_pc_s  = br_pc + AW'(PC_INC);
  assign br_disp_s = AW'({br_offset[29:0], 2'b00});

  // Branch wins when both redirect sources are active.
  always_comb begin
    target = seq_pc_s;
    if (br_taken) begin
      target = seq_pc_s + br_disp_s;
    end else begin
      target = AW'({seq_pc_s[AW-1:AW-4], jmp_index, 2'b00});
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: PC register, imem request/ack handshake and a one-entry output buffer.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_out,
  output logic [AW-1:0] pc_out,
  input  logic          br_taken,
  input  logic [AW-1:0] br_pc,
  input  logic [31:0]   br_offset,
  input  logic          jmp_en,
  input  logic [25:0]   jmp_index
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic          redir_pend_q, redir_pend_d;

  logic          redirect_s;
  logic          consume_s;
  logic [AW-1:0] target_s;

  assign redirect_s = br_taken | jmp_en;
  assign consume_s  = valid_q & inst_ready;

  fetch_target_calc #(.AW(AW)) u_target (
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .jmp_index (jmp_index),
    .br_taken  (br_taken),
    .target    (target_s)
  );

  // State register and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      inst_q       <= INST_NOP;
      pc_out_q     <= {AW{1'b0}};
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  // Next-state, PC and buffer update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    redir_pend_d = redir_pend_q;

    if (consume_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_s) begin
            pc_d         = target_s;
            valid_d      = 1'b0;
            redir_pend_d = 1'b0;
          end else if (redir_pend_q) begin
            // Response belongs to the pre-redirect address; discard it.
            redir_pend_d = 1'b0;
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = addr_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + AW'(PC_INC);
            if (!valid_q || consume_s) begin
              state_d = REQ;
            end else begin
              state_d = HOLD;
            end
          end
        end else if (redirect_s) begin
          // Outstanding request cannot be withdrawn: remember to drop its response.
          pc_d         = target_s;
          valid_d      = 1'b0;
          redir_pend_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (consume_s) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d      = IDLE;
        valid_d      = 1'b0;
        redir_pend_d = 1'b0;
      end
    endcase
  end

  // Request/address registers: address frozen while a request is outstanding.
  always_comb begin
    req_d = (state_d == REQ);
    if ((state_q == REQ) && !imem_ack) begin
      addr_d = addr_q;
    end else begin
      addr_d = {pc_d[AW-1:2], 2'b00};
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign pc_out     = pc_out_q;

endmodule
